maze_solver_param: RTL and testbench

Parametrised shortest-path maze solver: it receives an N×N binary maze serially and emits the shortest path from the top-left cell to the bottom-right cell, one coordinate per cycle. If no path exists, it flags the maze as invalid. It generalises the fixed 15×15 solver to any square size N and adds a deterministic tie-break rule, so outputs are bit-exact against the golden out_x/out_y files. It sits between the serial maze loader and the path-consumer/pattern bench.

---
 rtl/maze_solver_param.sv | 154 +++++++++++++++
 tb/tb_maze_solver_param.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/maze_solver_param.sv
// Shortest-path solver for a serially loaded MAZE_N x MAZE_N maze: a parallel flood
// from the goal builds per-cell back-pointers, then a cursor walks them from (0,0).
module maze_solver_param #(
   parameter int MAZE_N  = 15,
   parameter int COORD_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic               maze,
   output logic               out_valid,
   output logic               maze_not_valid,
   output logic [COORD_W-1:0] out_x,
   output logic [COORD_W-1:0] out_y
);

   localparam int NN    = MAZE_N * MAZE_N;
   localparam int CNT_W = $clog2(NN);

   typedef enum logic [2:0] {IDLE, LOAD, CHECK, FLOOD, TRACE, FAIL} state_t;

   state_t             state_q, state_d;
   logic [NN-1:0]      wall;
   logic [NN-1:0]      visited;
   logic [NN-1:0]      new_vis;
   logic [1:0]         ptr     [NN];
   logic [1:0]         new_ptr [NN];
   logic [CNT_W-1:0]   cnt;
   logic [COORD_W-1:0] cur_x, cur_y;
   logic [CNT_W-1:0]   cur_idx;
   logic               at_goal;
   logic               ends_blocked;

   // Pointer codes: 0 = right, 1 = down, 2 = left, 3 = up; priority in that order.
   for (genvar gy = 0; gy < MAZE_N; gy++) begin : g_row
      for (genvar gx = 0; gx < MAZE_N; gx++) begin : g_col
         localparam int I = gy * MAZE_N + gx;
         logic vr, vd, vl, vu;
         if (gx < MAZE_N - 1) begin : g_r
            assign vr = visited[I+1];
         end else begin : g_nr
            assign vr = 1'b0;
         end
         if (gy < MAZE_N - 1) begin : g_d
            assign vd = visited[I+MAZE_N];
         end else begin : g_nd
            assign vd = 1'b0;
         end
         if (gx > 0) begin : g_l
            assign vl = visited[I-1];
         end else begin : g_nl
            assign vl = 1'b0;
         end
         if (gy > 0) begin : g_u
            assign vu = visited[I-MAZE_N];
         end else begin : g_nu
            assign vu = 1'b0;
         end
         assign new_vis[I] = ~wall[I] & ~visited[I] & (vr | vd | vl | vu);
         assign new_ptr[I] = vr ? 2'd0 : vd ? 2'd1 : vl ? 2'd2 : 2'd3;
      end
   end

   always_comb begin
      cur_idx      = CNT_W'(int'(cur_y) * MAZE_N + int'(cur_x));
      at_goal      = (cur_x == COORD_W'(MAZE_N - 1)) && (cur_y == COORD_W'(MAZE_N - 1));
      ends_blocked = wall[0] | wall[NN-1];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (in_valid) state_d = LOAD;
         LOAD:  if (in_valid && cnt == CNT_W'(NN - 1)) state_d = CHECK;
         CHECK: state_d = ends_blocked ? FAIL : FLOOD;
         FLOOD: begin
            if (new_vis[0])      state_d = TRACE;
            else if (~|new_vis)  state_d = FAIL;
         end
         TRACE: if (at_goal) state_d = IDLE;
         FAIL:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wall    <= '0;
         visited <= '0;
         cnt     <= '0;
         cur_x   <= '0;
         cur_y   <= '0;
         for (int unsigned i = 0; i < NN; i++) ptr[i] <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               visited <= '0;
               if (in_valid) begin
                  wall[0] <= maze;
                  cnt     <= CNT_W'(1);
               end
            end
            LOAD: begin
               if (in_valid) begin
                  wall[cnt] <= maze;
                  cnt       <= cnt + CNT_W'(1);
               end
            end
            CHECK: begin
               cur_x <= '0;
               cur_y <= '0;
               if (!ends_blocked) visited[NN-1] <= 1'b1;
            end
            FLOOD: begin
               visited <= visited | new_vis;
               for (int unsigned i = 0; i < NN; i++)
                  if (new_vis[i]) ptr[i] <= new_ptr[i];
            end
            TRACE: begin
               if (at_goal) visited <= '0;
               case (ptr[cur_idx])
                  2'd0:    cur_x <= cur_x + COORD_W'(1);
                  2'd1:    cur_y <= cur_y + COORD_W'(1);
                  2'd2:    cur_x <= cur_x - COORD_W'(1);
                  default: cur_y <= cur_y - COORD_W'(1);
               endcase
            end
            FAIL: visited <= '0;
            default: ;
         endcase
      end
   end

   // Failure pulse is registered on entry to FAIL so it coincides with that state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid      <= 1'b0;
         maze_not_valid <= 1'b0;
         out_x          <= '0;
         out_y          <= '0;
      end else begin
         out_valid      <= (state_q == TRACE);
         maze_not_valid <= (state_d == FAIL);
         out_x          <= (state_q == TRACE) ? cur_x : '0;
         out_y          <= (state_q == TRACE) ? cur_y : '0;
      end
   end

endmodule

// File: tb/tb_maze_solver_param.sv
// Directed bench for maze_solver_param: a 15x15 and a 4x4 instance share clock and reset.
module tb_maze_solver_param;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       iv15 = 1'b0, mz15 = 1'b0, ov15, mnv15;
   logic [3:0] x15, y15;
   logic       iv4 = 1'b0, mz4 = 1'b0, ov4, mnv4;
   logic [1:0] x4, y4;

   int checks = 0;
   int errors = 0;

   logic m [256];
   int   px [64];
   int   py [64];
   int   n_out, n_mnv, n_rise, n_bad, first_ov, first_mnv;

   always #5 clk = ~clk;

   maze_solver_param #(.MAZE_N(15), .COORD_W(4)) dut15 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv15), .maze(mz15),
      .out_valid(ov15), .maze_not_valid(mnv15), .out_x(x15), .out_y(y15)
   );

   maze_solver_param #(.MAZE_N(4), .COORD_W(2)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .maze(mz4),
      .out_valid(ov4), .maze_not_valid(mnv4), .out_x(x4), .out_y(y4)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic fill(input int cells, input logic v);
      for (int i = 0; i < 256; i++) m[i] = (i < cells) ? v : 1'b0;
   endtask

   // Called just after a rising edge; leaves in_valid low after the last bit's edge.
   task automatic load(input int sel4, input int cells);
      for (int i = 0; i < cells; i++) begin
         if (sel4 != 0) begin iv4 = 1'b1; mz4 = m[i]; end
         else           begin iv15 = 1'b1; mz15 = m[i]; end
         @(posedge clk);
         #1;
      end
      iv4 = 1'b0; mz4 = 1'b0; iv15 = 1'b0; mz15 = 1'b0;
   endtask

   task automatic collect(input int sel4, input int cycles, input int stray, input int stop_at);
      logic ov, mnv, prev;
      int   x, y;
      n_out = 0; n_mnv = 0; n_rise = 0; n_bad = 0; first_ov = -1; first_mnv = -1;
      prev = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (stray != 0) begin
            if ((c < 10) || (c >= 32 && c <= 40)) begin iv15 = (c % 2 == 0); mz15 = 1'b1; end
            else begin iv15 = 1'b0; mz15 = 1'b0; end
         end
         ov  = (sel4 != 0) ? ov4  : ov15;
         mnv = (sel4 != 0) ? mnv4 : mnv15;
         x   = (sel4 != 0) ? int'(x4) : int'(x15);
         y   = (sel4 != 0) ? int'(y4) : int'(y15);
         if (ov) begin
            if (n_out < 64) begin px[n_out] = x; py[n_out] = y; end
            if (first_ov < 0) first_ov = c;
            n_out++;
            if (!prev) n_rise++;
         end else if (x != 0 || y != 0) begin
            n_bad++;
         end
         if (mnv) begin
            if (first_mnv < 0) first_mnv = c;
            n_mnv++;
            if (ov) n_bad++;
         end
         prev = ov;
         if (stop_at > 0 && n_out == stop_at) break;
      end
      iv15 = 1'b0; mz15 = 1'b0;
   endtask

   task automatic check_open_path(input string tag);
      chk({tag, "_len"}, n_out, 29);
      chk({tag, "_rises"}, n_rise, 1);
      chk({tag, "_mnv"}, n_mnv, 0);
      chk({tag, "_zero_idle"}, n_bad, 0);
      for (int k = 0; k < 29; k++) begin
         chk($sformatf("%s_x%0d", tag, k), px[k], (k <= 14) ? k : 14);
         chk($sformatf("%s_y%0d", tag, k), py[k], (k <= 14) ? 0 : k - 14);
      end
   endtask

   initial begin
      int ex4 [7];
      int ey4 [7];
      logic [15:0] rows4;
      ex4 = '{0, 1, 2, 2, 2, 3, 3};
      ey4 = '{0, 0, 0, 1, 2, 2, 3};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_ov15", int'(ov15), 0);
      chk("rst_mnv15", int'(mnv15), 0);
      chk("rst_x15", int'(x15), 0);
      chk("rst_y15", int'(y15), 0);
      chk("rst_ov4", int'(ov4), 0);
      chk("rst_mnv4", int'(mnv4), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // all-open 15x15: top row then right column
      fill(225, 1'b0);
      load(0, 225);
      collect(0, 300, 0, 0);
      check_open_path("open");
      chk("open_latency_ok", int'(first_ov >= 28 && first_ov <= 30), 1);

      // start cell blocked
      fill(225, 1'b0);
      m[0] = 1'b1;
      load(0, 225);
      collect(0, 300, 0, 0);
      chk("start_wall_len", n_out, 0);
      chk("start_wall_mnv", n_mnv, 1);
      chk("start_wall_lat_ok", int'(first_mnv >= 1 && first_mnv <= 2), 1);
      chk("start_wall_bad", n_bad, 0);

      // goal blocked
      fill(225, 1'b0);
      m[224] = 1'b1;
      load(0, 225);
      collect(0, 300, 0, 0);
      chk("goal_wall_len", n_out, 0);
      chk("goal_wall_mnv", n_mnv, 1);

      // row 7 fully walled: flood stalls
      fill(225, 1'b0);
      for (int x = 0; x < 15; x++) m[7*15 + x] = 1'b1;
      load(0, 225);
      collect(0, 300, 0, 0);
      chk("row7_len", n_out, 0);
      chk("row7_mnv", n_mnv, 1);
      chk("row7_bad", n_bad, 0);

      // 4x4 maze rows 0001/1001/0100/0110 (leftmost char is x=0)
      rows4 = 16'b0001_1001_0100_0110;
      fill(16, 1'b0);
      for (int i = 0; i < 16; i++) m[i] = rows4[15 - i];
      load(1, 16);
      collect(1, 60, 0, 0);
      chk("n4_len", n_out, 7);
      chk("n4_mnv", n_mnv, 0);
      chk("n4_rises", n_rise, 1);
      chk("n4_bad", n_bad, 0);
      for (int k = 0; k < 7; k++) begin
         chk($sformatf("n4_x%0d", k), px[k], ex4[k]);
         chk($sformatf("n4_y%0d", k), py[k], ey4[k]);
      end

      // asynchronous reset in the middle of a trace
      fill(225, 1'b0);
      load(0, 225);
      collect(0, 300, 0, 10);
      chk("mid_seen", n_out, 10);
      chk("mid_x9", px[9], 9);
      #1 rst_n = 1'b0;
      #1;
      chk("async_ov", int'(ov15), 0);
      chk("async_mnv", int'(mnv15), 0);
      chk("async_x", int'(x15), 0);
      chk("async_y", int'(y15), 0);
      repeat (2) @(negedge clk);
      chk("held_ov", int'(ov15), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // reload with stray in_valid pulses during flood and trace
      fill(225, 1'b0);
      load(0, 225);
      collect(0, 300, 1, 0);
      check_open_path("reload");

      // a second back-to-back solve proves the stray bits left no trace
      fill(225, 1'b0);
      load(0, 225);
      collect(0, 300, 0, 0);
      check_open_path("again");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
